planificador_ascensor: RTL and testbench
========================================

# planificador_ascensor

Request scheduler and motion/door sequencer for the 4-floor elevator. Latches hall and cabin buttons, picks direction with a collective (SCAN) policy, drives the motor and doors, and counts floors from the floor-change sensor. It sits between the button inputs and the motor/door actuators and provides the `estado` vector and floor display to the output interface.

## Interface
- `T_PUERTA`, default 8: door dwell time in clock cycles once doors report open.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `botones` in 10: button pulses or levels.
  - Hall-up: bit0 floor 1, bit2 floor 2, bit4 floor 3.
  - Hall-down: bit1 floor 2, bit3 floor 3, bit5 floor 4.
  - Cabin: bits 6..9 for floors 1..4.
- `boton_puertas` in 2: bit0 open-door, bit1 close-door (cabin buttons).
- `estado_puertas` in 2: 00 closed, 01 fully open, 10 moving.
- `cambio_piso` in 1: one-cycle pulse each time the car passes a floor boundary.
- `sensor_puertas` in 1: object between doors.
- `luces` out 10: pending-request register, same bit map as `botones`.
- `display` out 4: one-hot current floor (bit0 = floor 1).
- `aviso` out 4: one-hot arrival chime, one-cycle pulse.
- `puertas` out 2: 01 open, 10 close, 00 hold.
- `motor` out 2: 01 up, 10 down, 00 stop.
- `estado` out 4: bits[1:0] floor−1, bit2 direction (1 up), bit3 moving.

## Operation
- Request register `R`:
  - Set: `R <= R | botones` each cycle.
  - Clear: only at service (see arrival). If the same bit is set and cleared in one cycle, clear wins.
  - `luces = R`.
- For current floor f and direction d, define:
  - `here`: cabin[f] | up[f] | down[f].
  - `above` / `below`: any bit of R belonging to floors > f / < f.
- `stop(f, d)`:
  - up: cabin[f] | up[f] | (down[f] & !above).
  - down: cabin[f] | down[f] | (up[f] & !below).
- States: IDLE, MOVE, OPENING, OPEN, CLOSING.
- IDLE (motor 00, puertas 00):
  - `here` → clear floor-f bits, pulse aviso[f], go to OPENING.
  - Otherwise, a request in current d → MOVE in d.
  - Otherwise, a request in the opposite direction → flip d, then MOVE.
  - Otherwise stay in IDLE.
- MOVE (motor = d, estado bit3 = 1):
  - On `cambio_piso`, f ← f±1.
  - At the new floor, if `stop(f, d)` is true:
    - Clear cabin[f] and the hall bit(s) served: the d-direction hall bit; the opposite-direction hall bit only when it was the stop cause.
    - Pulse aviso[f], go to OPENING.
- OPENING (puertas 01): on `estado_puertas == 01` → OPEN, load counter with `T_PUERTA`.
- OPEN (puertas 00): the counter decrements each cycle.
  - Counter reloads on: `boton_puertas[0]`, `sensor_puertas`, or a new press for the current floor in the current direction or cabin (that press is not latched).
  - `boton_puertas[1]` forces the counter to 0.
  - At 0 → CLOSING.
- CLOSING (puertas 10):
  - `sensor_puertas`, `boton_puertas[0]`, or a press for the current floor → OPENING.
  - `estado_puertas == 00` → IDLE.
- Direction rules:
  - At floor 4, d is forced to down; at floor 1, d is forced to up.
  - In IDLE, re-evaluate d only when no request exists in d.
- Boundary behaviour:
  - `cambio_piso` outside MOVE is ignored.
  - `cambio_piso` in MOVE that would pass floor 4 or floor 1 is ignored (f saturates) and the motor stops, entering OPENING.
  - Doors never get 01/10 while motor ≠ 00. The motor never leaves 00 unless `estado_puertas == 00`.

## Timing
- Reset values:
  - state IDLE, f = floor 1, d = up, R = 0.
  - luces 0, display 0001, aviso 0, puertas 00, motor 00, estado 0100.
- All outputs are registered and change one cycle after the causing edge.
- Button press at cycle n → `luces` bit set at n+1.
- Pending request in IDLE with doors closed at cycle n → motor ≠ 00 at n+1.
- `cambio_piso` at n:
  - display and estado updated at n+1.
  - If stopping: motor 00, aviso pulse, and the served `luces` bits clear at n+1; puertas 01 at n+2.
- OPEN lasts exactly `T_PUERTA` cycles with no reload events, then puertas 10 on the next cycle.
- Reset mid-MOVE or mid-door: everything returns to the reset values on the next cycle. The floor count restarts at 1; floor re-homing is the system's responsibility.

## Test plan
- Reset, then cabin floor 3 (bit8):
  - motor 01 next cycle.
  - After two `cambio_piso` pulses: display 0100, aviso 0100 for one cycle, motor 00, bit8 cleared.
  - Then puertas 01.
- At floor 1, hall-down floor 4 (bit5) plus hall-up floor 2 (bit2):
  - Stops at floor 2 first; bit2 clears, bit5 stays.
  - Continues up to floor 4 and clears bit5 there.
- Doors OPEN with `T_PUERTA` = 8:
  - `sensor_puertas` at cycle 5 reloads the counter; puertas 10 appears 9 cycles after the sensor pulse.
  - `boton_puertas[1]` forces puertas 10 next cycle.
- In CLOSING, `sensor_puertas` asserted → puertas 01 next cycle, state OPENING; motor stays 00.
- Moving up at floor 2 with only hall-down floor 2 pending plus cabin floor 4:
  - No stop at floor 2.
  - Stop at floor 4, direction flips to down, then serves floor 2 (bit1 clears).
- `reset` asserted during MOVE → next cycle motor 00, display 0001, luces 0, estado 0100.

Source files
------------

// File: rtl/planificador_ascensor.sv
// Request scheduler and motion/door sequencer for a 4-floor elevator.
// Collective (SCAN) direction policy, registered motor/door/chime outputs.
module planificador_ascensor #(
  parameter int unsigned T_PUERTA = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] botones,
  input  logic [1:0] boton_puertas,
  input  logic [1:0] estado_puertas,
  input  logic       cambio_piso,
  input  logic       sensor_puertas,
  output logic [9:0] luces,
  output logic [3:0] display,
  output logic [3:0] aviso,
  output logic [1:0] puertas,
  output logic [1:0] motor,
  output logic [3:0] estado
);

  localparam int unsigned CW = (T_PUERTA < 2) ? 1 : $clog2(T_PUERTA + 1);

  localparam logic [1:0] MOT_STOP  = 2'b00;
  localparam logic [1:0] MOT_UP    = 2'b01;
  localparam logic [1:0] MOT_DOWN  = 2'b10;
  localparam logic [1:0] DOOR_HOLD = 2'b00;
  localparam logic [1:0] DOOR_OPEN = 2'b01;
  localparam logic [1:0] DOOR_CLOSE = 2'b10;

  typedef enum logic [2:0] {IDLE, MOVE, OPENING, OPEN, CLOSING} state_t;

  state_t        state;
  logic [1:0]    f;
  logic          d;
  logic [9:0]    r;
  logic [CW-1:0] cnt;

  // Request-bit masks per floor index (0 = floor 1)
  function automatic logic [9:0] floor_bits(input logic [1:0] fl);
    case (fl)
      2'd0:    floor_bits = 10'b0001000001;
      2'd1:    floor_bits = 10'b0010000110;
      2'd2:    floor_bits = 10'b0100011000;
      default: floor_bits = 10'b1000100000;
    endcase
  endfunction

  function automatic logic [9:0] up_bit(input logic [1:0] fl);
    case (fl)
      2'd0:    up_bit = 10'b0000000001;
      2'd1:    up_bit = 10'b0000000100;
      2'd2:    up_bit = 10'b0000010000;
      default: up_bit = 10'b0000000000;
    endcase
  endfunction

  function automatic logic [9:0] down_bit(input logic [1:0] fl);
    case (fl)
      2'd0:    down_bit = 10'b0000000000;
      2'd1:    down_bit = 10'b0000000010;
      2'd2:    down_bit = 10'b0000001000;
      default: down_bit = 10'b0000100000;
    endcase
  endfunction

  function automatic logic [9:0] cab_bit(input logic [1:0] fl);
    case (fl)
      2'd0:    cab_bit = 10'b0001000000;
      2'd1:    cab_bit = 10'b0010000000;
      2'd2:    cab_bit = 10'b0100000000;
      default: cab_bit = 10'b1000000000;
    endcase
  endfunction

  function automatic logic [9:0] above_mask(input logic [1:0] fl);
    case (fl)
      2'd0:    above_mask = 10'b1110111110;
      2'd1:    above_mask = 10'b1100111000;
      2'd2:    above_mask = 10'b1000100000;
      default: above_mask = 10'b0000000000;
    endcase
  endfunction

  function automatic logic [9:0] below_mask(input logic [1:0] fl);
    case (fl)
      2'd0:    below_mask = 10'b0000000000;
      2'd1:    below_mask = 10'b0001000001;
      2'd2:    below_mask = 10'b0011000111;
      default: below_mask = 10'b0111011111;
    endcase
  endfunction

  logic [9:0] req, served, clr_move, latched;
  logic [1:0] nf;
  logic       here, any_above, any_below, at_end;
  logic       n_cab, n_up, n_dn, n_above, n_below, opp_cause, stop_nf;
  logic       door_busy, press_served, press_floor;

  always_comb begin
    req       = r | botones;
    here      = |(req & floor_bits(f));
    any_above = |(req & above_mask(f));
    any_below = |(req & below_mask(f));
    at_end    = d ? (f == 2'd3) : (f == 2'd0);
    nf        = d ? f + 2'd1 : f - 2'd1;

    n_cab     = |(req & cab_bit(nf));
    n_up      = |(req & up_bit(nf));
    n_dn      = |(req & down_bit(nf));
    n_above   = |(req & above_mask(nf));
    n_below   = |(req & below_mask(nf));
    opp_cause = d ? (n_dn & !n_above) : (n_up & !n_below);
    // Terminal floors always stop so the car never overruns the shaft
    stop_nf   = n_cab | (d ? n_up : n_dn) | opp_cause | (nf == 2'd0) | (nf == 2'd3);
    clr_move  = cab_bit(nf) | (d ? up_bit(nf) : down_bit(nf))
              | (opp_cause ? (d ? down_bit(nf) : up_bit(nf)) : '0);

    // Presses already being served by the open/opening doors are not latched
    served       = cab_bit(f) | (d ? up_bit(f) : down_bit(f));
    door_busy    = (state == OPENING) || (state == OPEN) || (state == CLOSING);
    latched      = r | (botones & ~(door_busy ? served : '0));
    press_served = |(botones & served);
    press_floor  = |(botones & floor_bits(f));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      f       <= 2'd0;
      d       <= 1'b1;
      r       <= '0;
      cnt     <= '0;
      aviso   <= '0;
      puertas <= DOOR_HOLD;
      motor   <= MOT_STOP;
    end else begin
      aviso <= '0;
      r     <= latched;
      case (state)
        IDLE: begin
          puertas <= DOOR_HOLD;
          motor   <= MOT_STOP;
          if (here) begin
            r     <= latched & ~floor_bits(f);
            aviso <= 4'b0001 << f;
            state <= OPENING;
          end else if (estado_puertas == 2'b00) begin
            if (d ? any_above : any_below) begin
              state <= MOVE;
              motor <= d ? MOT_UP : MOT_DOWN;
            end else if (d ? any_below : any_above) begin
              d     <= ~d;
              state <= MOVE;
              motor <= d ? MOT_DOWN : MOT_UP;
            end
          end
        end
        MOVE: begin
          puertas <= DOOR_HOLD;
          if (cambio_piso) begin
            if (at_end) begin
              motor <= MOT_STOP;
              state <= OPENING;
            end else begin
              f <= nf;
              if (nf == 2'd3) d <= 1'b0;
              if (nf == 2'd0) d <= 1'b1;
              if (stop_nf) begin
                r     <= latched & ~clr_move;
                aviso <= 4'b0001 << nf;
                motor <= MOT_STOP;
                state <= OPENING;
              end
            end
          end
        end
        OPENING: begin
          if (estado_puertas == 2'b01) begin
            state   <= OPEN;
            cnt     <= CW'(T_PUERTA);
            puertas <= DOOR_HOLD;
          end else begin
            puertas <= DOOR_OPEN;
          end
        end
        OPEN: begin
          puertas <= DOOR_HOLD;
          if (boton_puertas[0] || sensor_puertas || press_served) begin
            cnt <= CW'(T_PUERTA);
          end else if (boton_puertas[1] || cnt <= CW'(1)) begin
            state   <= CLOSING;
            cnt     <= '0;
            puertas <= DOOR_CLOSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CLOSING: begin
          if (sensor_puertas || boton_puertas[0] || press_floor) begin
            state   <= OPENING;
            puertas <= DOOR_OPEN;
          end else if (estado_puertas == 2'b00) begin
            state   <= IDLE;
            puertas <= DOOR_HOLD;
          end else begin
            puertas <= DOOR_CLOSE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign luces   = r;
  assign display = 4'b0001 << f;
  assign estado  = {motor != MOT_STOP, d, f};

endmodule

// File: tb/tb_planificador_ascensor.sv
// Directed scenario bench for the elevator scheduler; expected values worked out by hand.
module tb_planificador_ascensor;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] botones;
  logic [1:0] boton_puertas;
  logic [1:0] estado_puertas;
  logic       cambio_piso;
  logic       sensor_puertas;
  logic [9:0] luces;
  logic [3:0] display;
  logic [3:0] aviso;
  logic [1:0] puertas;
  logic [1:0] motor;
  logic [3:0] estado;

  int tests = 0;
  int fails = 0;

  planificador_ascensor #(.T_PUERTA(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .botones        (botones),
    .boton_puertas  (boton_puertas),
    .estado_puertas (estado_puertas),
    .cambio_piso    (cambio_piso),
    .sensor_puertas (sensor_puertas),
    .luces          (luces),
    .display        (display),
    .aviso          (aviso),
    .puertas        (puertas),
    .motor          (motor),
    .estado         (estado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; botones = '0; boton_puertas = '0; estado_puertas = 2'b00;
    cambio_piso = 1'b0; sensor_puertas = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Walks a freshly entered OPENING state back to IDLE via the close button.
  task automatic door_cycle();
    tick();
    estado_puertas = 2'b01; tick();
    boton_puertas = 2'b10; tick();
    boton_puertas = 2'b00; estado_puertas = 2'b00; tick();
  endtask

  task automatic pulse_floor();
    cambio_piso = 1'b1; tick();
    cambio_piso = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({luces, display, aviso, puertas, motor, estado} !== {10'h000, 4'b0001, 4'b0000, 2'b00, 2'b00, 4'b0100})
      $display("FAIL reset_values: got l=%h disp=%b av=%b p=%b m=%b e=%b", luces, display, aviso, puertas, motor, estado);
    if ({luces, display, aviso, puertas, motor, estado} !== {10'h000, 4'b0001, 4'b0000, 2'b00, 2'b00, 4'b0100}) fails++;
  endtask

  task automatic test_ignore_cambio();
    do_reset();
    pulse_floor();
    tests++;
    if ({display, motor} !== {4'b0001, 2'b00}) begin
      fails++;
      $display("FAIL idle_cambio_ignored: got disp=%b m=%b, want disp=0001 m=00", display, motor);
    end
  endtask

  task automatic test_here_idle();
    do_reset();
    botones = 10'h040; tick();
    botones = '0;
    tests++;
    if ({luces, aviso, motor} !== {10'h000, 4'b0001, 2'b00}) begin
      fails++;
      $display("FAIL here_clear_wins: got l=%h av=%b m=%b, want l=000 av=0001 m=00", luces, aviso, motor);
    end
    door_cycle();
  endtask

  task automatic test_cabin3();
    do_reset();
    botones = 10'h100; tick();
    botones = '0;
    tests++;
    if ({motor, luces, estado} !== {2'b01, 10'h100, 4'b1100}) begin
      fails++;
      $display("FAIL cabin3_start: got m=%b l=%h e=%b, want m=01 l=100 e=1100", motor, luces, estado);
    end
    tick();
    pulse_floor();
    tests++;
    if ({display, motor, aviso} !== {4'b0010, 2'b01, 4'b0000}) begin
      fails++;
      $display("FAIL cabin3_pass_f2: got disp=%b m=%b av=%b, want 0010 01 0000", display, motor, aviso);
    end
    tick();
    pulse_floor();
    tests++;
    if ({display, aviso, motor, luces, puertas} !== {4'b0100, 4'b0100, 2'b00, 10'h000, 2'b00}) begin
      fails++;
      $display("FAIL cabin3_arrive: got disp=%b av=%b m=%b l=%h p=%b, want 0100 0100 00 000 00",
               display, aviso, motor, luces, puertas);
    end
    tick();
    tests++;
    if ({puertas, aviso} !== {2'b01, 4'b0000}) begin
      fails++;
      $display("FAIL cabin3_open: got p=%b av=%b, want p=01 av=0000", puertas, aviso);
    end
    estado_puertas = 2'b01; tick();
    boton_puertas = 2'b10; tick();
    boton_puertas = 2'b00;
    tests++;
    if (puertas !== 2'b10) begin
      fails++;
      $display("FAIL close_button: got p=%b, want p=10", puertas);
    end
    estado_puertas = 2'b00; tick();
  endtask

  task automatic test_scan();
    do_reset();
    botones = 10'h024; tick();
    botones = '0;
    pulse_floor();
    tests++;
    if ({luces, aviso, motor, display} !== {10'h020, 4'b0010, 2'b00, 4'b0010}) begin
      fails++;
      $display("FAIL scan_stop_f2: got l=%h av=%b m=%b disp=%b, want 020 0010 00 0010", luces, aviso, motor, display);
    end
    door_cycle();
    tick();
    tests++;
    if (motor !== 2'b01) begin
      fails++;
      $display("FAIL scan_resume: got m=%b, want m=01", motor);
    end
    pulse_floor();
    tests++;
    if ({display, motor, luces} !== {4'b0100, 2'b01, 10'h020}) begin
      fails++;
      $display("FAIL scan_pass_f3: got disp=%b m=%b l=%h, want 0100 01 020", display, motor, luces);
    end
    tick();
    pulse_floor();
    tests++;
    if ({luces, aviso, motor, display, estado} !== {10'h000, 4'b1000, 2'b00, 4'b1000, 4'b0011}) begin
      fails++;
      $display("FAIL scan_stop_f4: got l=%h av=%b m=%b disp=%b e=%b, want 000 1000 00 1000 0011",
               luces, aviso, motor, display, estado);
    end
  endtask

  // Continues from test_scan: car at floor 4, state OPENING.
  task automatic test_door_timer();
    tick();
    estado_puertas = 2'b01; tick();
    repeat (4) tick();
    sensor_puertas = 1'b1; tick();
    sensor_puertas = 1'b0;
    repeat (7) tick();
    tests++;
    if (puertas !== 2'b00) begin
      fails++;
      $display("FAIL sensor_reload_hold: got p=%b, want p=00 eight cycles after sensor", puertas);
    end
    tick();
    tests++;
    if (puertas !== 2'b10) begin
      fails++;
      $display("FAIL sensor_reload_close: got p=%b, want p=10 nine cycles after sensor", puertas);
    end
  endtask

  task automatic test_closing_reopen();
    estado_puertas = 2'b10; tick();
    sensor_puertas = 1'b1; tick();
    sensor_puertas = 1'b0;
    tests++;
    if ({puertas, motor} !== {2'b01, 2'b00}) begin
      fails++;
      $display("FAIL closing_reopen: got p=%b m=%b, want p=01 m=00", puertas, motor);
    end
    estado_puertas = 2'b01; tick();
    repeat (7) tick();
    tests++;
    if (puertas !== 2'b00) begin
      fails++;
      $display("FAIL open_len_hold: got p=%b, want p=00 in eighth open cycle", puertas);
    end
    tick();
    tests++;
    if (puertas !== 2'b10) begin
      fails++;
      $display("FAIL open_len_close: got p=%b, want p=10 after eight open cycles", puertas);
    end
    estado_puertas = 2'b00; tick();
    tests++;
    if ({puertas, estado} !== {2'b00, 4'b0011}) begin
      fails++;
      $display("FAIL closed_idle_f4: got p=%b e=%b, want p=00 e=0011", puertas, estado);
    end
  endtask

  task automatic test_opposite_hall();
    do_reset();
    botones = 10'h202; tick();
    botones = '0;
    pulse_floor();
    tests++;
    if ({aviso, motor, display, luces} !== {4'b0000, 2'b01, 4'b0010, 10'h202}) begin
      fails++;
      $display("FAIL opp_no_stop_f2: got av=%b m=%b disp=%b l=%h, want 0000 01 0010 202", aviso, motor, display, luces);
    end
    tick();
    pulse_floor();
    tick();
    pulse_floor();
    tests++;
    if ({luces, aviso, estado} !== {10'h002, 4'b1000, 4'b0011}) begin
      fails++;
      $display("FAIL opp_stop_f4: got l=%h av=%b e=%b, want 002 1000 0011", luces, aviso, estado);
    end
    door_cycle();
    tick();
    tests++;
    if ({motor, estado} !== {2'b10, 4'b1011}) begin
      fails++;
      $display("FAIL opp_go_down: got m=%b e=%b, want m=10 e=1011", motor, estado);
    end
    pulse_floor();
    tick();
    pulse_floor();
    tests++;
    if ({luces, aviso, motor, display} !== {10'h000, 4'b0010, 2'b00, 4'b0010}) begin
      fails++;
      $display("FAIL opp_serve_f2: got l=%h av=%b m=%b disp=%b, want 000 0010 00 0010", luces, aviso, motor, display);
    end
  endtask

  task automatic test_reset_in_move();
    do_reset();
    botones = 10'h200; tick();
    botones = '0;
    pulse_floor();
    tests++;
    if (estado !== 4'b1101) begin
      fails++;
      $display("FAIL move_before_reset: got e=%b, want e=1101", estado);
    end
    reset = 1'b1; tick();
    reset = 1'b0;
    tests++;
    if ({luces, display, aviso, puertas, motor, estado} !== {10'h000, 4'b0001, 4'b0000, 2'b00, 2'b00, 4'b0100}) begin
      fails++;
      $display("FAIL reset_in_move: got l=%h disp=%b av=%b p=%b m=%b e=%b", luces, display, aviso, puertas, motor, estado);
    end
  endtask

  initial begin
    test_reset();
    test_ignore_cambio();
    test_here_idle();
    test_cabin3();
    test_scan();
    test_door_timer();
    test_closing_reopen();
    test_opposite_hall();
    test_reset_in_move();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
